// File: rtl/battle_link_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// battle_link_ctrl
// Message-framing layer between the game logic and the serial com module.
//   TX: takes one (cmd, arg) message and feeds the frame SYNC, cmd, arg, CHK
//       byte-by-byte into the com module's parallel load / transmit interface.
//   RX: watches bytes from the com module, locks on SYNC, checks CHK and hands
//       validated messages to the game logic. Stalled frames time out.
//   CHK = SYNC ^ cmd ^ arg.
//
// Ports
//   CLOCK_50        in   system clock, everything on posedge
//   reset           in   synchronous, active-high
//   msg_valid       in   game logic offers a TX message
//   msg_cmd/msg_arg in   TX message bytes
//   msg_ready       out  TX idle; accept on msg_valid & msg_ready
//   tx_busy         out  TX frame in progress
//   P_data_in       out  byte presented to the com module
//   load            out  one-cycle load strobe to the com module
//   transmit_enable out  high while the com module shifts a byte out
//   char_sent       in   com module byte done (level, rising edge used)
//   P_data_out      in   received byte from the com module
//   char_received   in   com module byte ready (level, rising edge used)
//   rx_valid        out  one-cycle pulse, good frame received
//   rx_cmd/rx_arg   out  last good message, held until next rx_valid
//   rx_err          out  one-cycle pulse on checksum mismatch or timeout
// -----------------------------------------------------------------------------
module battle_link_ctrl #(
  parameter logic [7:0]           SYNC_BYTE      = 8'hA5,
  parameter int                   TIMEOUT_W      = 21,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 21'd1500000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       msg_valid,
  input  logic [7:0] msg_cmd,
  input  logic [7:0] msg_arg,
  output logic       msg_ready,
  output logic       tx_busy,
  output logic [7:0] P_data_in,
  output logic       load,
  output logic       transmit_enable,
  input  logic       char_sent,
  input  logic [7:0] P_data_out,
  input  logic       char_received,
  output logic       rx_valid,
  output logic [7:0] rx_cmd,
  output logic [7:0] rx_arg,
  output logic       rx_err
);

  typedef enum logic [1:0] {T_IDLE, T_LOAD, T_SEND, T_NEXT} tx_state_t;
  typedef enum logic [1:0] {R_SYNC, R_CMD, R_ARG, R_CHK}    rx_state_t;

  localparam logic [TIMEOUT_W-1:0] TO_ZERO = {TIMEOUT_W{1'b0}};
  localparam logic [TIMEOUT_W-1:0] TO_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_CYCLES - TO_ONE;

  // Frame check byte.
  function automatic logic [7:0] calc_chk(input logic [7:0] cmd_v,
                                          input logic [7:0] arg_v);
    calc_chk = SYNC_BYTE ^ cmd_v ^ arg_v;
  endfunction

  // Byte at position idx of the outgoing frame.
  function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                            input logic [7:0] cmd_v,
                                            input logic [7:0] arg_v,
                                            input logic [7:0] chk_v);
    case (idx)
      2'd0:    frame_byte = SYNC_BYTE;
      2'd1:    frame_byte = cmd_v;
      2'd2:    frame_byte = arg_v;
      2'd3:    frame_byte = chk_v;
      default: frame_byte = SYNC_BYTE;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Edge detection on the com module handshake levels
  // ---------------------------------------------------------------------------
  logic sent_prev_r;
  logic rcvd_prev_r;
  logic sent_evt_s;
  logic rcvd_evt_s;

  // One event per byte, no matter how long the com module holds its level.
  always_comb begin
    sent_evt_s = char_sent & ~sent_prev_r;
    rcvd_evt_s = char_received & ~rcvd_prev_r;
  end

  // Previous-cycle copies of the handshake levels.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sent_prev_r <= 1'b0;
      rcvd_prev_r <= 1'b0;
    end else begin
      sent_prev_r <= char_sent;
      rcvd_prev_r <= char_received;
    end
  end

  // ---------------------------------------------------------------------------
  // TX sequencer
  // ---------------------------------------------------------------------------
  tx_state_t  tx_state_r;
  logic [1:0] tx_idx_r;
  logic [7:0] tx_cmd_r;
  logic [7:0] tx_arg_r;
  logic [7:0] tx_chk_r;
  logic       msg_ready_r;
  logic       tx_busy_r;
  logic [7:0] p_data_r;
  logic       load_r;
  logic       tx_en_r;

  // TX FSM. Outputs are registered alongside the state: load_r is high
  // exactly while in T_LOAD and tx_en_r exactly while in T_SEND. The first
  // load is issued directly from the accept so it follows one cycle later.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tx_state_r  <= T_IDLE;
      tx_idx_r    <= 2'd0;
      tx_cmd_r    <= 8'h00;
      tx_arg_r    <= 8'h00;
      tx_chk_r    <= 8'h00;
      msg_ready_r <= 1'b1;
      tx_busy_r   <= 1'b0;
      p_data_r    <= 8'h00;
      load_r      <= 1'b0;
      tx_en_r     <= 1'b0;
    end else begin
      case (tx_state_r)
        T_IDLE: begin
          if (msg_valid) begin
            tx_cmd_r    <= msg_cmd;
            tx_arg_r    <= msg_arg;
            tx_chk_r    <= calc_chk(msg_cmd, msg_arg);
            tx_idx_r    <= 2'd0;
            msg_ready_r <= 1'b0;
            tx_busy_r   <= 1'b1;
            p_data_r    <= SYNC_BYTE;
            load_r      <= 1'b1;
            tx_state_r  <= T_LOAD;
          end
        end
        T_LOAD: begin
          load_r     <= 1'b0;
          tx_en_r    <= 1'b1;
          tx_state_r <= T_SEND;
        end
        T_SEND: begin
          // P_data_in stays put until the com module reports the byte done.
          if (sent_evt_s) begin
            tx_en_r    <= 1'b0;
            tx_state_r <= T_NEXT;
          end
        end
        T_NEXT: begin
          if (tx_idx_r == 2'd3) begin
            msg_ready_r <= 1'b1;
            tx_busy_r   <= 1'b0;
            tx_state_r  <= T_IDLE;
          end else begin
            tx_idx_r   <= tx_idx_r + 2'd1;
            p_data_r   <= frame_byte(tx_idx_r + 2'd1, tx_cmd_r, tx_arg_r, tx_chk_r);
            load_r     <= 1'b1;
            tx_state_r <= T_LOAD;
          end
        end
        default: begin
          msg_ready_r <= 1'b1;
          tx_busy_r   <= 1'b0;
          load_r      <= 1'b0;
          tx_en_r     <= 1'b0;
          tx_state_r  <= T_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX deframer with inter-byte timeout
  // ---------------------------------------------------------------------------
  rx_state_t            rx_state_r;
  logic [7:0]           rx_cmd_tmp_r;
  logic [7:0]           rx_arg_tmp_r;
  logic [7:0]           rx_cmd_r;
  logic [7:0]           rx_arg_r;
  logic                 rx_valid_r;
  logic                 rx_err_r;
  logic [TIMEOUT_W-1:0] to_cnt_r;

  // RX FSM. A byte event takes priority over a timeout in the same cycle.
  // SYNC values inside a frame are plain data; only R_SYNC hunts for SYNC.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rx_state_r   <= R_SYNC;
      rx_cmd_tmp_r <= 8'h00;
      rx_arg_tmp_r <= 8'h00;
      rx_cmd_r     <= 8'h00;
      rx_arg_r     <= 8'h00;
      rx_valid_r   <= 1'b0;
      rx_err_r     <= 1'b0;
      to_cnt_r     <= TO_ZERO;
    end else begin
      rx_valid_r <= 1'b0;
      rx_err_r   <= 1'b0;
      case (rx_state_r)
        R_SYNC: begin
          to_cnt_r <= TO_ZERO;
          if (rcvd_evt_s && (P_data_out == SYNC_BYTE)) begin
            rx_state_r <= R_CMD;
          end
        end
        R_CMD, R_ARG, R_CHK: begin
          if (rcvd_evt_s) begin
            to_cnt_r <= TO_ZERO;
            case (rx_state_r)
              R_CMD: begin
                rx_cmd_tmp_r <= P_data_out;
                rx_state_r   <= R_ARG;
              end
              R_ARG: begin
                rx_arg_tmp_r <= P_data_out;
                rx_state_r   <= R_CHK;
              end
              R_CHK: begin
                if (P_data_out == calc_chk(rx_cmd_tmp_r, rx_arg_tmp_r)) begin
                  rx_cmd_r   <= rx_cmd_tmp_r;
                  rx_arg_r   <= rx_arg_tmp_r;
                  rx_valid_r <= 1'b1;
                end else begin
                  rx_err_r <= 1'b1;
                end
                rx_state_r <= R_SYNC;
              end
              default: rx_state_r <= R_SYNC;
            endcase
          end else if (to_cnt_r == TO_LAST) begin
            to_cnt_r   <= TO_ZERO;
            rx_err_r   <= 1'b1;
            rx_state_r <= R_SYNC;
          end else begin
            to_cnt_r <= to_cnt_r + TO_ONE;
          end
        end
        default: begin
          to_cnt_r   <= TO_ZERO;
          rx_state_r <= R_SYNC;
        end
      endcase
    end
  end

  assign msg_ready       = msg_ready_r;
  assign tx_busy         = tx_busy_r;
  assign P_data_in       = p_data_r;
  assign load            = load_r;
  assign transmit_enable = tx_en_r;
  assign rx_valid        = rx_valid_r;
  assign rx_cmd          = rx_cmd_r;
  assign rx_arg          = rx_arg_r;
  assign rx_err          = rx_err_r;

endmodule
